// File: rtl/rcc_pclk_div_sel_ctrl.sv
// Shadowed writer for the APB/timer clock divider select. A config write is held until the
// divider reports a period boundary, or is forced in (with a sticky error) after a watchdog window.
module rcc_pclk_div_sel_ctrl #(
  parameter int               DIV_W       = 3,
  parameter logic [DIV_W-1:0] RST_DIV_SEL = '0,
  parameter int               TIMEOUT     = 32,
  parameter int               SETTLE_CYC  = 2
) (
  input  logic             i_clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_div_sel,
  input  logic             cfg_timpre,
  input  logic             err_clr,
  input  logic             div_en,
  output logic [DIV_W-1:0] div_sel,
  output logic             timpre,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             err
);

  localparam int CFG_W = DIV_W + 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ST_W  = $clog2(SETTLE_CYC + 1);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYC);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    SETTLE,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CFG_W-1:0] shadow, shadow_nxt;
  logic [CFG_W-1:0] pend, pend_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic [WD_W-1:0]  wdog, wdog_nxt;
  logic [ST_W-1:0]  settle_cnt, settle_nxt;
  logic [DIV_W-1:0] div_sel_nxt;
  logic             timpre_nxt;
  logic             err_nxt;
  logic [CFG_W-1:0] applied;
  logic [CFG_W-1:0] req;
  logic             req_vld;

  assign applied = {timpre, div_sel};

  // req/req_vld carry the request picked this cycle (IDLE write, or DONE's newest-first choice)
  always_comb begin
    state_nxt    = state;
    shadow_nxt   = shadow;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    wdog_nxt     = wdog;
    settle_nxt   = settle_cnt;
    div_sel_nxt  = div_sel;
    timpre_nxt   = timpre;
    err_nxt      = err;
    req          = '0;
    req_vld      = 1'b0;

    if (err_clr) begin
      err_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (cfg_wr) begin
          req     = {cfg_timpre, cfg_div_sel};
          req_vld = 1'b1;
        end
      end

      WAIT_EDGE: begin
        if (cfg_wr) begin
          pend_nxt     = {cfg_timpre, cfg_div_sel};
          pend_vld_nxt = 1'b1;
        end
        if (div_en) begin
          {timpre_nxt, div_sel_nxt} = shadow;
          settle_nxt                = '0;
          state_nxt                 = SETTLE;
        end else if (wdog == WD_LAST) begin
          {timpre_nxt, div_sel_nxt} = shadow;
          err_nxt                   = 1'b1;
          settle_nxt                = '0;
          state_nxt                 = SETTLE;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end

      SETTLE: begin
        if (cfg_wr) begin
          pend_nxt     = {cfg_timpre, cfg_div_sel};
          pend_vld_nxt = 1'b1;
        end
        if (settle_cnt == ST_LAST) begin
          state_nxt = DONE;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end

      DONE: begin
        if (cfg_wr) begin
          req          = {cfg_timpre, cfg_div_sel};
          req_vld      = 1'b1;
          pend_vld_nxt = 1'b0;
        end else if (pend_vld) begin
          req          = pend;
          req_vld      = 1'b1;
          pend_vld_nxt = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // A request matching what the divider already runs completes without waiting for a boundary
    if (req_vld) begin
      shadow_nxt = req;
      if (req == applied) begin
        state_nxt = DONE;
      end else begin
        wdog_nxt  = '0;
        state_nxt = WAIT_EDGE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
      wdog       <= '0;
      settle_cnt <= '0;
      div_sel    <= RST_DIV_SEL;
      timpre     <= 1'b0;
      cfg_busy   <= 1'b0;
      cfg_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      shadow     <= shadow_nxt;
      pend       <= pend_nxt;
      pend_vld   <= pend_vld_nxt;
      wdog       <= wdog_nxt;
      settle_cnt <= settle_nxt;
      div_sel    <= div_sel_nxt;
      timpre     <= timpre_nxt;
      cfg_busy   <= (state_nxt == WAIT_EDGE) || (state_nxt == SETTLE);
      cfg_done   <= (state_nxt == DONE);
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_rcc_pclk_div_sel_ctrl.sv
// Directed bench for rcc_pclk_div_sel_ctrl: boundary apply, equal value, timeout, pending
// replacement, asynchronous reset and the err/div_en collision cases.
module tb_rcc_pclk_div_sel_ctrl;

  logic       i_clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [2:0] cfg_div_sel = 3'b000;
  logic       cfg_timpre = 1'b0;
  logic       err_clr = 1'b0;
  logic       div_en = 1'b0;
  logic [2:0] div_sel;
  logic       timpre;
  logic       cfg_busy;
  logic       cfg_done;
  logic       err;

  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  logic saw_110 = 1'b0;
  logic mon_en = 1'b0;

  rcc_pclk_div_sel_ctrl #(
    .DIV_W      (3),
    .RST_DIV_SEL(3'b000),
    .TIMEOUT    (32),
    .SETTLE_CYC (2)
  ) dut (
    .i_clk      (i_clk),
    .rst        (rst),
    .cfg_wr     (cfg_wr),
    .cfg_div_sel(cfg_div_sel),
    .cfg_timpre (cfg_timpre),
    .err_clr    (err_clr),
    .div_en     (div_en),
    .div_sel    (div_sel),
    .timpre     (timpre),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .err        (err)
  );

  always #5 i_clk = ~i_clk;

  // Sampled on the falling edge so each registered value is seen exactly once
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (cfg_done) done_cnt++;
      if (div_sel == 3'b110) saw_110 = 1'b1;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_cfg(input logic [2:0] d, input logic t);
    cfg_div_sel = d;
    cfg_timpre  = t;
    cfg_wr      = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (div_sel !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_div_sel: got %b expected 000", div_sel);
    end
    vectors++;
    if ({timpre, cfg_busy, cfg_done, err} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {timpre, cfg_busy, cfg_done, err});
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_normal();
    do_reset();
    write_cfg(3'b101, 1'b0);
    vectors++;
    if ({cfg_busy, div_sel} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL normal_wait: got busy,div_sel=%b expected 1000", {cfg_busy, div_sel});
    end
    repeat (4) tick();
    div_en = 1'b1;
    tick();
    div_en = 1'b0;
    vectors++;
    if ({timpre, div_sel} !== 4'b0101) begin
      miscompares++;
      $display("[TB] FAIL normal_apply: got %b expected 0101", {timpre, div_sel});
    end
    tick();
    vectors++;
    if ({cfg_busy, cfg_done} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL normal_settle: got busy,done=%b expected 10", {cfg_busy, cfg_done});
    end
    tick();
    tick();
    vectors++;
    if ({cfg_busy, cfg_done, err} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL normal_done: got busy,done,err=%b expected 010", {cfg_busy, cfg_done, err});
    end
    tick();
    vectors++;
    if ({cfg_busy, cfg_done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL normal_idle: got busy,done=%b expected 00", {cfg_busy, cfg_done});
    end
  endtask

  task automatic test_timpre();
    do_reset();
    write_cfg(3'b000, 1'b1);
    vectors++;
    if (cfg_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timpre_busy: got %b expected 1", cfg_busy);
    end
    div_en = 1'b1;
    tick();
    div_en = 1'b0;
    vectors++;
    if ({timpre, div_sel} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL timpre_apply: got %b expected 1000", {timpre, div_sel});
    end
    repeat (3) tick();
  endtask

  task automatic test_equal();
    do_reset();
    write_cfg(3'b000, 1'b0);
    vectors++;
    if ({cfg_busy, cfg_done, div_sel} !== 5'b01000) begin
      miscompares++;
      $display("[TB] FAIL equal_done: got busy,done,div_sel=%b expected 01000", {cfg_busy, cfg_done, div_sel});
    end
    tick();
    vectors++;
    if ({cfg_busy, cfg_done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL equal_after: got busy,done=%b expected 00", {cfg_busy, cfg_done});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    write_cfg(3'b110, 1'b0);
    repeat (31) tick();
    vectors++;
    if ({cfg_busy, err, div_sel} !== 5'b10000) begin
      miscompares++;
      $display("[TB] FAIL timeout_early: got busy,err,div_sel=%b expected 10000", {cfg_busy, err, div_sel});
    end
    tick();
    vectors++;
    if ({err, div_sel} !== 4'b1110) begin
      miscompares++;
      $display("[TB] FAIL timeout_apply: got err,div_sel=%b expected 1110", {err, div_sel});
    end
    repeat (3) tick();
    vectors++;
    if ({cfg_done, err} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL timeout_done: got done,err=%b expected 11", {cfg_done, err});
    end
    repeat (3) tick();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_sticky: got %b expected 1", err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_clear: got %b expected 0", err);
    end
  endtask

  task automatic test_collision();
    do_reset();
    write_cfg(3'b001, 1'b0);
    repeat (31) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if ({err, div_sel} !== 4'b1001) begin
      miscompares++;
      $display("[TB] FAIL collide_errclr: got err,div_sel=%b expected 1001", {err, div_sel});
    end
    repeat (4) tick();
    do_reset();
    write_cfg(3'b010, 1'b0);
    repeat (31) tick();
    div_en = 1'b1;
    tick();
    div_en = 1'b0;
    vectors++;
    if ({err, div_sel} !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL collide_diven: got err,div_sel=%b expected 0010", {err, div_sel});
    end
    repeat (3) tick();
    vectors++;
    if ({cfg_done, err} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL collide_done: got done,err=%b expected 10", {cfg_done, err});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    done_cnt = 0;
    saw_110  = 1'b0;
    mon_en   = 1'b1;
    write_cfg(3'b101, 1'b0);
    write_cfg(3'b110, 1'b0);
    write_cfg(3'b111, 1'b0);
    div_en = 1'b1;
    tick();
    div_en = 1'b0;
    vectors++;
    if (div_sel !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got %b expected 101", div_sel);
    end
    repeat (3) tick();
    vectors++;
    if (cfg_done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_done1: got %b expected 1", cfg_done);
    end
    tick();
    vectors++;
    if ({cfg_busy, div_sel} !== 4'b1101) begin
      miscompares++;
      $display("[TB] FAIL b2b_pending: got busy,div_sel=%b expected 1101", {cfg_busy, div_sel});
    end
    repeat (2) tick();
    div_en = 1'b1;
    tick();
    div_en = 1'b0;
    vectors++;
    if (div_sel !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got %b expected 111", div_sel);
    end
    repeat (6) tick();
    mon_en = 1'b0;
    vectors++;
    if (done_cnt !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_cnt);
    end
    vectors++;
    if (saw_110 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_dropped: got saw_110=%b expected 0", saw_110);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_cfg(3'b100, 1'b0);
    div_en = 1'b1;
    tick();
    div_en = 1'b0;
    repeat (4) tick();
    write_cfg(3'b011, 1'b0);
    repeat (2) tick();
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({cfg_busy, div_sel} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL rstmid_async: got busy,div_sel=%b expected 0000", {cfg_busy, div_sel});
    end
    tick();
    rst = 1'b0;
    tick();
    div_en = 1'b1;
    tick();
    div_en = 1'b0;
    repeat (4) tick();
    vectors++;
    if ({cfg_busy, cfg_done, div_sel} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL rstmid_after: got busy,done,div_sel=%b expected 00000", {cfg_busy, cfg_done, div_sel});
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timpre();
    test_equal();
    test_timeout();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: got no completion expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
